// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: frame state encoding and default link parameters,
// used by both the transmit and receive ends of the serial link.
package uart_tx_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_STOP_BITS    = 1;

  function automatic int frameCycles(input int dataWidth, input int clksPerBit,
                                     input int stopBits);
    return (1 + dataWidth + stopBits) * clksPerBit;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// Shared with the receive path; clr restarts the bit period on every state entry.
module uart_baud_counter
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clkCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkCnt <= '0;
    end else if (clr || clkCnt == LAST) begin
      clkCnt <= '0;
    end else begin
      clkCnt <= clkCnt + 1'b1;
    end
  end

  assign tick = (clkCnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a word on valid/ready and sends start, LSB-first data
// and stop bits. Outputs decode registered state only, so reset idles the line at once.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  txState_t state, nextState;
  logic [BW-1:0]         bitCnt;
  logic [DATA_WIDTH-1:0] shReg;
  logic                  bitTick;
  logic                  clrBaud;
  logic                  accept;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) baudCounter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clrBaud),
    .tick (bitTick)
  );

  assign accept  = (state == IDLE) && tx_valid;
  assign clrBaud = (nextState != state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    tx_ready  = 1'b0;
    tx_busy   = 1'b1;
    tx_serial = 1'b1;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
        if (accept) nextState = START;
      end
      START: begin
        tx_serial = 1'b0;
        if (bitTick) nextState = DATA;
      end
      DATA: begin
        tx_serial = shReg[0];
        if (bitTick && bitCnt == LAST_DATA) nextState = STOP;
      end
      STOP: begin
        // bitCnt counts stop bits here, so two-stop-bit frames reuse the same counter
        if (bitTick && bitCnt == LAST_STOP) begin
          tx_done   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitCnt <= '0;
      shReg  <= '0;
    end else begin
      if (clrBaud) begin
        bitCnt <= '0;
      end else if (bitTick && (state == DATA || state == STOP)) begin
        bitCnt <= bitCnt + 1'b1;
      end
      if (accept) begin
        shReg <= tx_data;
      end else if (state == DATA && bitTick) begin
        shReg <= shReg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (8/4/1 and 8/16/2) checked against
// a frame model built from the bit list start, data LSB-first, stop bits.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic       validA, validB;
  logic [7:0] dataA, dataB;
  logic       readyA, serA, busyA, doneA;
  logic       readyB, serB, busyB, doneB;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .tx_data(dataA), .tx_valid(validA),
    .tx_ready(readyA), .tx_serial(serA), .tx_busy(busyA), .tx_done(doneA)
  );

  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .STOP_BITS(2)) dutB (
    .clk(clk), .rst(rst), .tx_data(dataB), .tx_valid(validB),
    .tx_ready(readyB), .tx_serial(serB), .tx_busy(busyB), .tx_done(doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic obsSer(input int w);
    return (w != 0) ? serB : serA;
  endfunction
  function automatic logic obsReady(input int w);
    return (w != 0) ? readyB : readyA;
  endfunction
  function automatic logic obsBusy(input int w);
    return (w != 0) ? busyB : busyA;
  endfunction
  function automatic logic obsDone(input int w);
    return (w != 0) ? doneB : doneA;
  endfunction

  task automatic setIn(input int w, input logic v, input logic [7:0] d);
    if (w != 0) begin
      validB = v;
      dataB  = d;
    end else begin
      validA = v;
      dataA  = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input int w);
    chk("idle_serial", 32'(obsSer(w)), 32'd1);
    chk("idle_ready", 32'(obsReady(w)), 32'd1);
    chk("idle_busy", 32'(obsBusy(w)), 32'd0);
    chk("idle_done", 32'(obsDone(w)), 32'd0);
  endtask

  // Offers a word and returns in cycle 1 of its frame with tx_valid dropped.
  task automatic handshake(input int w, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    setIn(w, 1'b1, d);
    for (int i = 0; i < 400; i++) begin
      if (obsReady(w)) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    setIn(w, 1'b0, d);
    if (!ok) chk("hs_timeout", 32'd0, 32'd1);
  endtask

  // Checks every cycle of one frame from cycle 1; returns in cycle N+1.
  task automatic checkFrame(input int w, input logic [7:0] d, input bit churn,
                            output int dones);
    int cpb, sb, n, idx, busyCnt, stopHigh;
    logic bits[$];
    logic [7:0] dec;
    cpb = (w != 0) ? 16 : 4;
    sb  = (w != 0) ? 2 : 1;
    n   = (1 + 8 + sb) * cpb;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    dec = 8'h00;
    busyCnt = 0;
    stopHigh = 0;
    dones = 0;
    for (int k = 1; k <= n; k++) begin
      idx = (k - 1) / cpb;
      chk("frame_serial", 32'(obsSer(w)), 32'(bits[idx]));
      chk("frame_busy", 32'(obsBusy(w)), 32'd1);
      chk("frame_ready", 32'(obsReady(w)), 32'd0);
      chk("frame_done", 32'(obsDone(w)), 32'(k == n));
      if (obsBusy(w)) busyCnt++;
      if (obsDone(w)) dones++;
      if (idx >= 1 && idx <= 8 && ((k - 1) % cpb) == cpb / 2) dec[idx-1] = obsSer(w);
      if (idx > 8 && obsSer(w)) stopHigh++;
      if (churn) begin
        if (k >= n - 1) setIn(w, 1'b0, 8'($urandom));
        else setIn(w, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      tick();
    end
    chk("frame_len", 32'(busyCnt), 32'(n));
    chk("stop_high", 32'(stopHigh), 32'(sb * cpb));
    chk("decode", 32'(dec), 32'(d));
    chk("after_busy", 32'(obsBusy(w)), 32'd0);
    chk("after_ready", 32'(obsReady(w)), 32'd1);
  endtask

  initial begin
    int d1, d2;
    logic [7:0] word;
    int w;
    rst = 1'b0;
    setIn(0, 1'b0, 8'h00);
    setIn(1, 1'b0, 8'h00);

    // 1. reset and idle
    repeat (3) tick();
    chkIdle(0);
    chkIdle(1);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chkIdle(0);
      chkIdle(1);
      tick();
    end

    // 2. single frame 0xA5
    handshake(0, 8'hA5);
    checkFrame(0, 8'hA5, 1'b0, d1);
    chk("a5_done_count", 32'(d1), 32'd1);
    chkIdle(0);
    repeat (3) tick();

    // 3. back-to-back 0x00 then 0xFF with tx_valid held
    handshake(0, 8'h00);
    setIn(0, 1'b1, 8'hFF);
    checkFrame(0, 8'h00, 1'b0, d1);
    chk("b2b_gap_serial", 32'(serA), 32'd1);
    tick();
    setIn(0, 1'b0, 8'h00);
    checkFrame(0, 8'hFF, 1'b0, d2);
    chk("b2b_done_count", 32'(d1 + d2), 32'd2);
    repeat (2) tick();

    // 4. data and valid churn while busy
    handshake(0, 8'h3C);
    checkFrame(0, 8'h3C, 1'b1, d1);
    setIn(0, 1'b0, 8'h00);
    repeat (2) tick();

    // 5. async reset during data bit 3
    word = 8'($urandom);
    handshake(0, word);
    repeat (17) tick();
    chk("pre_rst_bit3", 32'(serA), 32'(word[3]));
    #2;
    rst = 1'b0;
    #1;
    chk("rst_serial", 32'(serA), 32'd1);
    chk("rst_busy", 32'(busyA), 32'd0);
    chk("rst_ready", 32'(readyA), 32'd1);
    chk("rst_done", 32'(doneA), 32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    chkIdle(0);
    handshake(0, 8'h81);
    checkFrame(0, 8'h81, 1'b0, d1);

    // 6. two stop bits at 16 clocks per bit
    handshake(1, 8'h5A);
    checkFrame(1, 8'h5A, 1'b0, d1);
    chk("b_done_count", 32'(d1), 32'd1);
    chkIdle(1);

    // randomized frames with random gaps and churn
    for (int r = 0; r < 6; r++) begin
      w = r % 2;
      word = 8'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      handshake(w, word);
      checkFrame(w, word, 1'($urandom_range(0, 1)), d1);
      setIn(w, 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
